// File: rtl/countdown_timer_pkg.sv
// Shared types and constants for the BCD min:sec countdown controller.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package countdown_timer_pkg;

   // Controller states; encodings are fixed so they can be probed on a bus.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_ALARM = 2'd3
   } state_t;

   // Largest legal code for a BCD ones digit and for a mod-60 tens digit.
   localparam logic [3:0] BCD_ONES_MAX = 4'd9;
   localparam logic [3:0] BCD_TENS_MAX = 4'd5;

   // Alarm auto-clear length in 1 s strobes (timeout build only).
   localparam int ALARM_SEC_DEFAULT = 10;

   // Mod-60 BCD increment: 59 wraps to 00. Returns {tens, ones}.
   function automatic logic [7:0] bcd60_inc(input logic [3:0] tens,
                                            input logic [3:0] ones);
      logic [3:0] t;
      logic [3:0] o;
      t = tens;
      o = ones;
      if (ones >= BCD_ONES_MAX) begin
         o = 4'd0;
         t = (tens >= BCD_TENS_MAX) ? 4'd0 : tens + 4'd1;
      end else begin
         o = ones + 4'd1;
      end
      return {t, o};
   endfunction

   // Mod-60 BCD decrement: 00 wraps to 59. Returns {tens, ones}.
   function automatic logic [7:0] bcd60_dec(input logic [3:0] tens,
                                            input logic [3:0] ones);
      logic [3:0] t;
      logic [3:0] o;
      t = tens;
      o = ones;
      if (ones == 4'd0) begin
         o = BCD_ONES_MAX;
         t = (tens == 4'd0) ? BCD_TENS_MAX : tens - 4'd1;
      end else begin
         o = ones - 4'd1;
      end
      return {t, o};
   endfunction

endpackage

// File: rtl/bcd_mod60_cell.sv
// One two-digit mod-60 BCD counter (seconds or minutes) with inc/dec/clear.
// Latency: digits update on the clk edge after inc/dec/clr; borrow_out/is_zero are combinational.
// Backpressure: none; every qualified request is applied in the cycle it is seen.
module bcd_mod60_cell
   import countdown_timer_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic       inc,
   input  logic       dec,
   input  logic       clr,
   input  logic       borrow_in,   // a higher cell can lend when this one is at 00
   output logic [3:0] ones,
   output logic [3:0] tens,
   output logic       borrow_out,  // this decrement wraps 00->59 and needs a lend
   output logic       is_zero
);

   logic [3:0] ones_q, ones_d;
   logic [3:0] tens_q, tens_d;
   logic       at_zero;

   assign at_zero = (ones_q == 4'd0) && (tens_q == 4'd0);

   // Next digit value: clear wins, then increment, then decrement. A decrement
   // from 00 with nothing to borrow from saturates, so 00:00 never underflows.
   always_comb begin
      ones_d = ones_q;
      tens_d = tens_q;
      if (clr) begin
         ones_d = 4'd0;
         tens_d = 4'd0;
      end else if (inc) begin
         {tens_d, ones_d} = bcd60_inc(tens_q, ones_q);
      end else if (dec) begin
         if (!at_zero || borrow_in) begin
            {tens_d, ones_d} = bcd60_dec(tens_q, ones_q);
         end
      end
   end

   // Digit registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ones_q <= 4'd0;
         tens_q <= 4'd0;
      end else begin
         ones_q <= ones_d;
         tens_q <= tens_d;
      end
   end

   assign borrow_out = dec && !clr && !inc && at_zero && borrow_in;
   assign is_zero    = at_zero;
   assign ones       = ones_q;
   assign tens       = tens_q;

endmodule

// File: rtl/countdown_timer_ctrl.sv
// Countdown sequencer: preset via inc buttons, start/pause/resume, alarm at 00:00.
// Latency: BCD digits and flags are registered, one clk edge after the causing pulse/strobe.
// Backpressure: none; lower-priority pulses and an overridden clk_sec are dropped.
// Build option COUNTDOWN_ALARM_TIMEOUT_EN: alarm auto-clears after ALARM_SEC strobes.
module countdown_timer_ctrl
   import countdown_timer_pkg::*;
#(
   parameter int ALARM_SEC = ALARM_SEC_DEFAULT
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       clk_sec,
   input  logic       btn_start_stop,
   input  logic       btn_inc_min,
   input  logic       btn_inc_sec,
   input  logic       btn_clear,
   output logic [3:0] sec1,
   output logic [3:0] sec10,
   output logic [3:0] min1,
   output logic [3:0] min10,
   output logic       running,
   output logic       paused,
   output logic       alarm
);

   state_t state_q, state_d;
   logic   running_q, running_d;
   logic   paused_q, paused_d;
   logic   alarm_q, alarm_d;

   logic   clr_p, ss_p, imin_p, isec_p, any_btn;
   logic   sec_inc, min_inc, val_clr, sec_dec;
   logic   sec_zero, min_zero, sec_borrow, min_borrow_unused;
   logic   time_nonzero, last_second;
   logic   alarm_timeout;

   // Button priority: clear > start_stop > inc_min > inc_sec, one winner per cycle.
   always_comb begin
      clr_p   = btn_clear;
      ss_p    = !btn_clear && btn_start_stop;
      imin_p  = !btn_clear && !btn_start_stop && btn_inc_min;
      isec_p  = !btn_clear && !btn_start_stop && !btn_inc_min && btn_inc_sec;
      any_btn = btn_clear || btn_start_stop || btn_inc_min || btn_inc_sec;
   end

   // Seconds cell: borrows from minutes only when minutes are non-zero.
   bcd_mod60_cell u_sec (
      .clk        (clk),
      .reset_n    (reset_n),
      .inc        (sec_inc),
      .dec        (sec_dec),
      .clr        (val_clr),
      .borrow_in  (!min_zero),
      .ones       (sec1),
      .tens       (sec10),
      .borrow_out (sec_borrow),
      .is_zero    (sec_zero)
   );

   // Minutes cell: decremented only by a seconds wrap; it is the top cell, so
   // there is nothing above it to borrow from.
   bcd_mod60_cell u_min (
      .clk        (clk),
      .reset_n    (reset_n),
      .inc        (min_inc),
      .dec        (sec_borrow),
      .clr        (val_clr),
      .borrow_in  (1'b0),
      .ones       (min1),
      .tens       (min10),
      .borrow_out (min_borrow_unused),
      .is_zero    (min_zero)
   );

   assign time_nonzero = !(sec_zero && min_zero);
   // 00:01: the next decrement lands on 00:00, so the alarm is raised on that edge.
   assign last_second  = min_zero && (sec10 == 4'd0) && (sec1 == 4'd1);

`ifdef COUNTDOWN_ALARM_TIMEOUT_EN
   localparam int ALARM_CNT_W = (ALARM_SEC > 1) ? $clog2(ALARM_SEC) : 1;
   localparam logic [ALARM_CNT_W-1:0] ALARM_CNT_LAST = ALARM_CNT_W'(ALARM_SEC - 1);

   logic [ALARM_CNT_W-1:0] alarm_cnt_q, alarm_cnt_d;

   assign alarm_timeout = (state_q == ST_ALARM) && clk_sec && !any_btn
                          && (alarm_cnt_q == ALARM_CNT_LAST);

   // Strobes seen in ALARM; held at zero elsewhere so every alarm starts fresh.
   always_comb begin
      alarm_cnt_d = alarm_cnt_q;
      if (state_q != ST_ALARM || any_btn || alarm_timeout) begin
         alarm_cnt_d = '0;
      end else if (clk_sec) begin
         alarm_cnt_d = alarm_cnt_q + 1'b1;
      end
   end

   // Alarm timeout counter register.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         alarm_cnt_q <= '0;
      end else begin
         alarm_cnt_q <= alarm_cnt_d;
      end
   end
`else
   // ALARM_SEC only matters for the timeout build; the alarm waits for a button here.
   localparam int ALARM_SEC_UNUSED = ALARM_SEC;
   assign alarm_timeout = 1'b0;
`endif

   // Next state and counter controls. A button acted on in RUN suppresses the
   // strobe for that cycle; the lost second is not made up later.
   always_comb begin
      state_d = state_q;
      sec_inc = 1'b0;
      min_inc = 1'b0;
      val_clr = 1'b0;
      sec_dec = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (clr_p) begin
               val_clr = 1'b1;
            end else if (ss_p) begin
               if (time_nonzero) begin
                  state_d = ST_RUN;
               end
            end else if (imin_p) begin
               min_inc = 1'b1;
            end else if (isec_p) begin
               sec_inc = 1'b1;
            end
         end
         ST_RUN: begin
            if (clr_p) begin
               val_clr = 1'b1;
               state_d = ST_IDLE;
            end else if (ss_p) begin
               state_d = ST_PAUSE;
            end else if (clk_sec) begin
               sec_dec = 1'b1;
               if (last_second) begin
                  state_d = ST_ALARM;
               end
            end
         end
         ST_PAUSE: begin
            if (clr_p) begin
               val_clr = 1'b1;
               state_d = ST_IDLE;
            end else if (ss_p) begin
               state_d = ST_RUN;
            end
         end
         ST_ALARM: begin
            // Value is already 00:00; clearing just keeps it pinned there.
            if (any_btn) begin
               val_clr = 1'b1;
               state_d = ST_IDLE;
            end else if (alarm_timeout) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            val_clr = 1'b1;
            state_d = ST_IDLE;
         end
      endcase
   end

   // Status flags track the state being entered so they move with the digits.
   always_comb begin
      running_d = (state_d == ST_RUN);
      paused_d  = (state_d == ST_PAUSE);
      alarm_d   = (state_d == ST_ALARM);
   end

   // State and flag registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         running_q <= 1'b0;
         paused_q  <= 1'b0;
         alarm_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         running_q <= running_d;
         paused_q  <= paused_d;
         alarm_q   <= alarm_d;
      end
   end

   assign running = running_q;
   assign paused  = paused_q;
   assign alarm   = alarm_q;

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Directed bench for countdown_timer_ctrl: a vector table plus multi-cycle sequences.
// Inputs are driven on the falling edge; outputs are checked 1 ns after the rising edge.
module tb_countdown_timer_ctrl;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       clk_sec = 1'b0;
   logic       btn_start_stop = 1'b0;
   logic       btn_inc_min = 1'b0;
   logic       btn_inc_sec = 1'b0;
   logic       btn_clear = 1'b0;
   logic [3:0] sec1, sec10, min1, min10;
   logic       running, paused, alarm;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   countdown_timer_ctrl #(.ALARM_SEC(3)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .clk_sec        (clk_sec),
      .btn_start_stop (btn_start_stop),
      .btn_inc_min    (btn_inc_min),
      .btn_inc_sec    (btn_inc_sec),
      .btn_clear      (btn_clear),
      .sec1           (sec1),
      .sec10          (sec10),
      .min1           (min1),
      .min10          (min10),
      .running        (running),
      .paused         (paused),
      .alarm          (alarm)
   );

   typedef struct {
      logic        rst_n;
      logic        clr;
      logic        ss;
      logic        imin;
      logic        isec;
      logic        tick;
      logic [15:0] exp_t;     // {min10, min1, sec10, sec1} as hex digits
      logic        exp_run;
      logic        exp_pause;
      logic        exp_alarm;
   } vec_t;

   localparam int NVEC = 22;
   vec_t vecs[NVEC];

   function automatic vec_t mk(input logic rn, input logic c, input logic s,
                               input logic m, input logic i, input logic t,
                               input logic [15:0] et, input logic er,
                               input logic ep, input logic ea);
      vec_t v;
      v.rst_n = rn; v.clr = c; v.ss = s; v.imin = m; v.isec = i; v.tick = t;
      v.exp_t = et; v.exp_run = er; v.exp_pause = ep; v.exp_alarm = ea;
      return v;
   endfunction

   // One clock of stimulus, then pulses drop back to idle.
   task automatic apply(input logic rn, input logic c, input logic s,
                        input logic m, input logic i, input logic t);
      @(negedge clk);
      reset_n = rn; btn_clear = c; btn_start_stop = s;
      btn_inc_min = m; btn_inc_sec = i; clk_sec = t;
      @(posedge clk);
      #1;
      reset_n = 1'b1; btn_clear = 1'b0; btn_start_stop = 1'b0;
      btn_inc_min = 1'b0; btn_inc_sec = 1'b0; clk_sec = 1'b0;
   endtask

   task automatic check(input string nm, input logic [15:0] et,
                        input logic er, input logic ep, input logic ea);
      logic [18:0] act;
      logic [18:0] expv;
      act  = {min10, min1, sec10, sec1, running, paused, alarm};
      expv = {et, er, ep, ea};
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %h%h:%h%h run=%b pause=%b alarm=%b, want %h run=%b pause=%b alarm=%b",
                  nm, min10, min1, sec10, sec1, running, paused, alarm, et, er, ep, ea);
      end
   endtask

   initial begin
      //               rn c  s  m  i  t   time     r  p  a
      vecs[0]  = mk(0, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 0); // reset
      vecs[1]  = mk(1, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 0);
      vecs[2]  = mk(1, 0, 0, 0, 1, 0, 16'h0001, 0, 0, 0); // inc_sec x3
      vecs[3]  = mk(1, 0, 0, 0, 1, 0, 16'h0002, 0, 0, 0);
      vecs[4]  = mk(1, 0, 0, 0, 1, 0, 16'h0003, 0, 0, 0);
      vecs[5]  = mk(1, 0, 0, 1, 0, 0, 16'h0103, 0, 0, 0); // inc_min x2
      vecs[6]  = mk(1, 0, 0, 1, 0, 0, 16'h0203, 0, 0, 0);
      vecs[7]  = mk(1, 0, 1, 0, 0, 0, 16'h0203, 1, 0, 0); // start
      vecs[8]  = mk(1, 0, 0, 0, 0, 1, 16'h0202, 1, 0, 0); // first strobe
      vecs[9]  = mk(1, 0, 0, 0, 0, 0, 16'h0202, 1, 0, 0);
      vecs[10] = mk(1, 0, 1, 0, 0, 0, 16'h0202, 0, 1, 0); // pause
      vecs[11] = mk(1, 0, 0, 0, 0, 1, 16'h0202, 0, 1, 0); // strobe ignored
      vecs[12] = mk(1, 0, 0, 0, 1, 0, 16'h0202, 0, 1, 0); // inc ignored
      vecs[13] = mk(1, 0, 1, 0, 0, 0, 16'h0202, 1, 0, 0); // resume
      vecs[14] = mk(1, 0, 0, 0, 0, 1, 16'h0201, 1, 0, 0);
      vecs[15] = mk(1, 0, 1, 0, 0, 1, 16'h0201, 0, 1, 0); // ss beats strobe
      vecs[16] = mk(1, 1, 0, 0, 1, 0, 16'h0000, 0, 0, 0); // clear beats inc
      vecs[17] = mk(1, 0, 1, 0, 0, 0, 16'h0000, 0, 0, 0); // start at 00:00
      vecs[18] = mk(1, 0, 0, 1, 0, 0, 16'h0100, 0, 0, 0);
      vecs[19] = mk(1, 0, 1, 0, 0, 0, 16'h0100, 1, 0, 0);
      vecs[20] = mk(1, 0, 0, 1, 0, 0, 16'h0100, 1, 0, 0); // inc ignored in RUN
      vecs[21] = mk(1, 0, 0, 0, 0, 1, 16'h0059, 1, 0, 0); // borrow from minutes

      for (int k = 0; k < NVEC; k++) begin
         apply(vecs[k].rst_n, vecs[k].clr, vecs[k].ss, vecs[k].imin,
               vecs[k].isec, vecs[k].tick);
         check($sformatf("vec%0d", k), vecs[k].exp_t, vecs[k].exp_run,
               vecs[k].exp_pause, vecs[k].exp_alarm);
      end

      // Run 00:59 down to the alarm.
      repeat (58) apply(1, 0, 0, 0, 0, 1);
      check("run_to_0001", 16'h0001, 1, 0, 0);
      apply(1, 0, 0, 0, 0, 1);
      check("alarm_entry", 16'h0000, 0, 0, 1);

`ifdef COUNTDOWN_ALARM_TIMEOUT_EN
      repeat (2) apply(1, 0, 0, 0, 0, 1);
      check("alarm_before_timeout", 16'h0000, 0, 0, 1);
      apply(1, 0, 0, 0, 0, 1);
      check("alarm_timeout", 16'h0000, 0, 0, 0);
`else
      repeat (20) apply(1, 0, 0, 0, 0, 1);
      check("alarm_persists", 16'h0000, 0, 0, 1);
      apply(1, 1, 0, 0, 0, 0);
      check("alarm_clear_exit", 16'h0000, 0, 0, 0);
`endif

      // Alarm left by start_stop goes to IDLE, not back to RUN.
      apply(1, 0, 0, 0, 1, 0);
      apply(1, 0, 1, 0, 0, 0);
      apply(1, 0, 0, 0, 0, 1);
      check("alarm_from_0001", 16'h0000, 0, 0, 1);
      apply(1, 0, 1, 0, 0, 0);
      check("alarm_ss_exit", 16'h0000, 0, 0, 0);

      // Seconds wrap 59->00 without touching minutes.
      apply(1, 0, 0, 1, 0, 0);
      repeat (59) apply(1, 0, 0, 0, 1, 0);
      check("sec_at_59", 16'h0159, 0, 0, 0);
      apply(1, 0, 0, 0, 1, 0);
      check("sec_wrap", 16'h0100, 0, 0, 0);

      // Minutes wrap 59->00.
      apply(1, 1, 0, 0, 0, 0);
      repeat (59) apply(1, 0, 0, 1, 0, 0);
      check("min_at_59", 16'h5900, 0, 0, 0);
      apply(1, 0, 0, 1, 0, 0);
      check("min_wrap", 16'h0000, 0, 0, 0);

      // 10:00 -> 09:59 borrows through the minutes tens digit; clear in RUN.
      repeat (10) apply(1, 0, 0, 1, 0, 0);
      apply(1, 0, 1, 0, 0, 0);
      apply(1, 0, 0, 0, 0, 1);
      check("min_tens_borrow", 16'h0959, 1, 0, 0);
      apply(1, 1, 0, 0, 0, 0);
      check("run_clear", 16'h0000, 0, 0, 0);

      // Pause at 00:30 freezes the value; resume decrements on the next strobe.
      repeat (30) apply(1, 0, 0, 0, 1, 0);
      apply(1, 0, 1, 0, 0, 0);
      apply(1, 0, 1, 0, 0, 0);
      check("pause_0030", 16'h0030, 0, 1, 0);
      repeat (5) apply(1, 0, 0, 0, 0, 1);
      check("pause_frozen", 16'h0030, 0, 1, 0);
      apply(1, 0, 1, 0, 0, 0);
      check("resume", 16'h0030, 1, 0, 0);
      apply(1, 0, 0, 0, 0, 1);
      check("resume_dec", 16'h0029, 1, 0, 0);

      // Reset mid-RUN zeroes everything and stays idle afterwards.
      apply(0, 0, 0, 0, 0, 0);
      check("reset_mid_run", 16'h0000, 0, 0, 0);
      apply(1, 0, 0, 0, 0, 1);
      check("after_reset", 16'h0000, 0, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
